// File: rtl/pipeline_execute.sv
// Execute stage of the RV32 core: ALU plus an optional iterative radix-2 divider.
// Define EX_DIV_EN to build the divider; without it divide ops return 0 in a single cycle.
module pipeline_execute (
  input  logic        clk,
  input  logic        reset,
  input  logic        validD,
  input  logic        flushE,
  input  logic        regWriteEnD,
  input  logic [1:0]  resultSrcD,
  input  logic        memWriteEnD,
  input  logic [3:0]  memOpTypeD,
  input  logic [4:0]  aluOpD,
  input  logic [31:0] srcAD,
  input  logic [31:0] srcBD,
  input  logic [31:0] writeDataD,
  output logic        stallE,
  output logic        regWriteEnE,
  output logic [1:0]  resultSrcE,
  output logic        memWriteEnE,
  output logic [3:0]  memOpTypeE,
  output logic [31:0] aluResultE,
  output logic [31:0] memWriteDataE
);

  // Encodings shared with definitions.vh
  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;
`ifdef EX_DIV_EN
  localparam logic [4:0] ALU_DIV   = 5'd11;
  localparam logic [4:0] ALU_DIVU  = 5'd12;
  localparam logic [4:0] ALU_REM   = 5'd13;
  localparam logic [4:0] ALU_REMU  = 5'd14;
`endif
  localparam logic [3:0] NO_MEM    = 4'hF;

  logic        r_reg_write_e;
  logic [1:0]  r_result_src_e;
  logic        r_mem_write_e;
  logic [3:0]  r_mem_op_e;
  logic [31:0] r_alu_result_e;
  logic [31:0] r_mem_wdata_e;

  logic [31:0] w_alu_result;
  logic        w_load;
  logic        w_nxt_reg_write;
  logic [1:0]  w_nxt_result_src;
  logic        w_nxt_mem_write;
  logic [3:0]  w_nxt_mem_op;
  logic [31:0] w_nxt_result;
  logic [31:0] w_nxt_wdata;

  // Divide ops fall to the default and yield 0 when the divider is absent
  always_comb begin
    w_alu_result = '0;
    case (aluOpD)
      ALU_ADD:   w_alu_result = srcAD + srcBD;
      ALU_SUB:   w_alu_result = srcAD - srcBD;
      ALU_SLL:   w_alu_result = srcAD << srcBD[4:0];
      ALU_SLT:   w_alu_result = {31'd0, $signed(srcAD) < $signed(srcBD)};
      ALU_SLTU:  w_alu_result = {31'd0, srcAD < srcBD};
      ALU_XOR:   w_alu_result = srcAD ^ srcBD;
      ALU_SRL:   w_alu_result = srcAD >> srcBD[4:0];
      ALU_SRA:   w_alu_result = $unsigned($signed(srcAD) >>> srcBD[4:0]);
      ALU_OR:    w_alu_result = srcAD | srcBD;
      ALU_AND:   w_alu_result = srcAD & srcBD;
      ALU_PASSB: w_alu_result = srcBD;
      default:   w_alu_result = '0;
    endcase
  end

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {StIdle, StRun, StDone} div_state_e;

  div_state_e  r_state;
  logic [4:0]  r_count;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_divisor;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_is_rem;
  logic        r_p_reg_write;
  logic [1:0]  r_p_result_src;
  logic        r_p_mem_write;
  logic [3:0]  r_p_mem_op;
  logic [31:0] r_p_wdata;

  logic        w_is_div;
  logic        w_op_signed;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_rem_shift;
  logic [32:0] w_diff;
  logic [31:0] w_div_result;

  assign w_is_div    = (aluOpD == ALU_DIV) || (aluOpD == ALU_DIVU) ||
                       (aluOpD == ALU_REM) || (aluOpD == ALU_REMU);
  assign w_op_signed = (aluOpD == ALU_DIV) || (aluOpD == ALU_REM);
  assign w_abs_a     = (w_op_signed && srcAD[31]) ? (~srcAD + 32'd1) : srcAD;
  assign w_abs_b     = (w_op_signed && srcBD[31]) ? (~srcBD + 32'd1) : srcBD;

  // Restoring step: a zero divisor naturally yields all-ones quotient and rem = dividend
  assign w_rem_shift = {r_rem, r_quo[31]};
  assign w_diff      = w_rem_shift - {1'b0, r_divisor};

  assign w_div_result = r_is_rem ? (r_neg_r ? (~r_rem + 32'd1) : r_rem)
                                 : (r_neg_q ? (~r_quo + 32'd1) : r_quo);

  assign stallE = !reset &&
                  (((r_state == StIdle) && validD && w_is_div && !flushE) || (r_state == StRun));

  always_ff @(posedge clk) begin
    if (reset || flushE) begin
      r_state <= StIdle;
      r_count <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (validD && w_is_div) begin
            r_state        <= StRun;
            r_count        <= '0;
            r_quo          <= w_abs_a;
            r_rem          <= '0;
            r_divisor      <= w_abs_b;
            // Divide-by-zero keeps the raw all-ones quotient, so never negate it
            r_neg_q        <= w_op_signed && (srcAD[31] ^ srcBD[31]) && (srcBD != '0);
            r_neg_r        <= w_op_signed && srcAD[31];
            r_is_rem       <= (aluOpD == ALU_REM) || (aluOpD == ALU_REMU);
            r_p_reg_write  <= regWriteEnD;
            r_p_result_src <= resultSrcD;
            r_p_mem_write  <= memWriteEnD;
            r_p_mem_op     <= memOpTypeD;
            r_p_wdata      <= writeDataD;
          end
        end
        StRun: begin
          if (!w_diff[32]) begin
            r_rem <= w_diff[31:0];
            r_quo <= {r_quo[30:0], 1'b1};
          end else begin
            r_rem <= w_rem_shift[31:0];
            r_quo <= {r_quo[30:0], 1'b0};
          end
          r_count <= r_count + 5'd1;
          if (r_count == 5'd31) r_state <= StDone;
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end
`else
  assign stallE = 1'b0;
`endif

  always_comb begin
    w_load           = validD;
    w_nxt_reg_write  = regWriteEnD;
    w_nxt_result_src = resultSrcD;
    w_nxt_mem_write  = memWriteEnD;
    w_nxt_mem_op     = memOpTypeD;
    w_nxt_result     = w_alu_result;
    w_nxt_wdata      = writeDataD;
`ifdef EX_DIV_EN
    w_load = 1'b0;
    if (r_state == StIdle) begin
      w_load = validD && !w_is_div;
    end else if (r_state == StDone) begin
      w_load           = 1'b1;
      w_nxt_reg_write  = r_p_reg_write;
      w_nxt_result_src = r_p_result_src;
      w_nxt_mem_write  = r_p_mem_write;
      w_nxt_mem_op     = r_p_mem_op;
      w_nxt_result     = w_div_result;
      w_nxt_wdata      = r_p_wdata;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset || flushE || !w_load) begin
      r_reg_write_e  <= 1'b0;
      r_result_src_e <= '0;
      r_mem_write_e  <= 1'b0;
      r_mem_op_e     <= NO_MEM;
      r_alu_result_e <= '0;
      r_mem_wdata_e  <= '0;
    end else begin
      r_reg_write_e  <= w_nxt_reg_write;
      r_result_src_e <= w_nxt_result_src;
      r_mem_write_e  <= w_nxt_mem_write;
      r_mem_op_e     <= w_nxt_mem_op;
      r_alu_result_e <= w_nxt_result;
      r_mem_wdata_e  <= w_nxt_wdata;
    end
  end

  assign regWriteEnE   = r_reg_write_e;
  assign resultSrcE    = r_result_src_e;
  assign memWriteEnE   = r_mem_write_e;
  assign memOpTypeE    = r_mem_op_e;
  assign aluResultE    = r_alu_result_e;
  assign memWriteDataE = r_mem_wdata_e;

endmodule
